// File: rtl/detector_jogada.sv
`default_nettype none
// detector_jogada: synchronizes, debounces and validates single-button presses for the game datapath.
// Rev 1.0
module detector_jogada #(
  parameter int DEBOUNCE_CICLOS = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  input  logic       zera,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       multipla,
  output logic [3:0] db_estado
);

  localparam int            CW       = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [3:0] {
    ESPERA       = 4'd0,
    FILTRA       = 4'd1,
    PULSO        = 4'd2,
    SOLTA        = 4'd3,
    FILTRA_SOLTA = 4'd4,
    MULTIPLA     = 4'd5
  } estado_t;

  estado_t       estado;
  logic [3:0]    sinc_a;
  logic [3:0]    sinc;
  logic [3:0]    amostra;
  logic [CW-1:0] contador;
  logic          amostra_unica;

  assign amostra_unica = (amostra != 4'd0) && ((amostra & (amostra - 4'd1)) == 4'd0);
  assign db_estado     = estado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sinc_a <= 4'd0;
      sinc   <= 4'd0;
    end else begin
      sinc_a <= botoes;
      sinc   <= sinc_a;
    end
  end

  // Counter defaults to zero so it is cleared on every state entry; only the
  // two filtering states advance it while they stay put.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= ESPERA;
      amostra      <= 4'd0;
      contador     <= '0;
      jogada       <= 4'd0;
      jogada_feita <= 1'b0;
      multipla     <= 1'b0;
    end else begin
      contador     <= '0;
      jogada_feita <= 1'b0;
      multipla     <= 1'b0;
      if (zera) jogada <= 4'd0;

      case (estado)
        ESPERA: begin
          if (habilita && (sinc != 4'd0)) begin
            amostra <= sinc;
            estado  <= FILTRA;
          end
        end
        FILTRA: begin
          if (!habilita) begin
            estado <= SOLTA;
          end else if (sinc != amostra) begin
            estado <= ESPERA;
          end else if (contador == CONT_MAX) begin
            if (amostra_unica) begin
              jogada       <= amostra;
              jogada_feita <= 1'b1;
              estado       <= PULSO;
            end else begin
              multipla <= 1'b1;
              estado   <= MULTIPLA;
            end
          end else begin
            contador <= contador + CW'(1);
          end
        end
        PULSO, MULTIPLA: begin
          estado <= SOLTA;
        end
        SOLTA: begin
          if (sinc == 4'd0) estado <= FILTRA_SOLTA;
        end
        FILTRA_SOLTA: begin
          if (sinc != 4'd0) begin
            estado <= SOLTA;
          end else if (contador == CONT_MAX) begin
            estado <= ESPERA;
          end else begin
            contador <= contador + CW'(1);
          end
        end
        default: begin
          estado <= ESPERA;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
